// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending change logic.
//   state_t : transaction states IDLE / CALC / DISP / DONE
//   SEL_*   : coin_sel denomination codes driven towards the coin mechanism
//             (00 = LO, 01 = MID, 10 = HI; 11 is never driven)
// -----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DISP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SEL_LO  = 2'b00;
    localparam logic [1:0] SEL_MID = 2'b01;
    localparam logic [1:0] SEL_HI  = 2'b10;

endpackage

// File: rtl/change_sub.sv
// -----------------------------------------------------------------------------
// change_sub
// W-bit two's-complement subtractor used to form the change amount.
//   a      in  W  minuend (amount paid)
//   b      in  W  subtrahend (item price)
//   diff   out W  low W bits of a - b
//   borrow out 1  high when a < b
// -----------------------------------------------------------------------------
module change_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    // a + ~b + 1 in W+1 bits: the carry out is set exactly when no borrow occurred.
    assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum[W-1:0];
    assign borrow = ~sum[W];

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Computes change for a purchase and pays it out one coin at a time using a
// greedy choice of HI / MID / LO denominations over a valid/ready handshake.
//
// Parameters
//   W         width of paid, price and change
//   COIN_HI   largest denomination
//   COIN_MID  middle denomination
//   COIN_LO   smallest denomination (must be 1 so any amount can be paid)
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start          request a transaction; only looked at in IDLE
//   paid, price    transaction operands, latched on an accepted start
//   busy           high whenever not IDLE
//   done           one-cycle pulse that ends each transaction
//   short_err      pulses with done when paid < price
//   change         paid - price (0 when short), held until the next CALC
//   coin_valid     a coin request is being presented
//   coin_ready     coin mechanism accepts the presented request
//   coin_sel       denomination code of the presented request
//   coin_cnt       (CHANGE_DISPENSER_COUNT_EN only) coins accepted in the
//                  current transaction
//
// Build option: define CHANGE_DISPENSER_COUNT_EN to add the coin_cnt output.
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int W        = 8,
    parameter int COIN_HI  = 10,
    parameter int COIN_MID = 5,
    parameter int COIN_LO  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] paid,
    input  logic [W-1:0] price,
    output logic         busy,
    output logic         done,
    output logic         short_err,
    output logic [W-1:0] change,
    output logic         coin_valid,
    input  logic         coin_ready,
    output logic [1:0]   coin_sel
`ifdef CHANGE_DISPENSER_COUNT_EN
    ,
    output logic [W-1:0] coin_cnt
`endif
);

    import vend_pkg::*;

    localparam logic [W-1:0] HI_V  = W'(COIN_HI);
    localparam logic [W-1:0] MID_V = W'(COIN_MID);
    localparam logic [W-1:0] LO_V  = W'(COIN_LO);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] paid_q;
    logic [W-1:0] price_q;
    logic [W-1:0] remaining;
    logic         short_q;
    logic [W-1:0] diff;
    logic         borrow;
    logic [1:0]   sel;
    logic [W-1:0] coin_val;
    logic         accept;

    change_sub #(.W(W)) u_sub (
        .a      (paid_q),
        .b      (price_q),
        .diff   (diff),
        .borrow (borrow)
    );

    // Greedy pick of the largest coin that still fits. remaining only moves on
    // an accepted coin, so the selection is naturally stable during a stall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        sel      = SEL_LO;
        coin_val = LO_V;
        if (remaining >= HI_V) begin
            sel      = SEL_HI;
            coin_val = HI_V;
        end else if (remaining >= MID_V) begin
            sel      = SEL_MID;
            coin_val = MID_V;
        end
    end

    assign accept = (state == DISP) && coin_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= state_nxt;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        done       = 1'b0;
        short_err  = 1'b0;
        coin_valid = 1'b0;
        coin_sel   = SEL_LO;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CALC;
            end
            CALC: begin
                if (borrow || (diff == '0)) state_nxt = DONE;
                else                        state_nxt = DISP;
            end
            DISP: begin
                coin_valid = 1'b1;
                coin_sel   = sel;
                if (accept && (remaining == coin_val)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                short_err = short_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: only the control/data registers below are reset; there is no
        // memory here that would need to be left out of the reset.
        if (rst) begin
            paid_q    <= '0;
            price_q   <= '0;
            change    <= '0;
            remaining <= '0;
            short_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        paid_q  <= paid;
                        price_q <= price;
                        short_q <= 1'b0;
                    end
                end
                CALC: begin
                    if (borrow) begin
                        change    <= '0;
                        remaining <= '0;
                        short_q   <= 1'b1;
                    end else begin
                        change    <= diff;
                        remaining <= diff;
                    end
                end
                DISP: begin
                    if (accept) remaining <= remaining - coin_val;
                end
                default: ;
            endcase
        end
    end

`ifdef CHANGE_DISPENSER_COUNT_EN
    // Accepted-coin counter: cleared by an accepted start, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            coin_cnt <= '0;
        end else if (accept) begin
            coin_cnt <= coin_cnt + W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Scoreboard bench for change_dispenser: stimulus pushes expected coins and
// transaction results computed with plain arithmetic; a negedge monitor pops
// and compares whenever a coin is accepted or done pulses.
// -----------------------------------------------------------------------------
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] paid;
    logic [W-1:0] price;
    logic         busy;
    logic         done;
    logic         short_err;
    logic [W-1:0] change;
    logic         coin_valid;
    logic         coin_ready;
    logic [1:0]   coin_sel;
`ifdef CHANGE_DISPENSER_COUNT_EN
    logic [W-1:0] coin_cnt;
`endif

    change_dispenser #(.W(W), .COIN_HI(10), .COIN_MID(5), .COIN_LO(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .paid       (paid),
        .price      (price),
        .busy       (busy),
        .done       (done),
        .short_err  (short_err),
        .change     (change),
        .coin_valid (coin_valid),
        .coin_ready (coin_ready),
        .coin_sel   (coin_sel)
`ifdef CHANGE_DISPENSER_COUNT_EN
        ,
        .coin_cnt   (coin_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int change;
        int short_e;
        int ncoins;
        int exp_stall;   // -1 when the stall count is not constrained
    } txn_t;

    txn_t       txn_q[$];
    logic [1:0] coin_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int coins_seen = 0;
    int stalls = 0;
    int done_seen = 0;
    logic       stalled_prev = 1'b0;
    logic [1:0] stalled_sel = 2'b00;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall_left cycles
    int stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: greedy change with plain integer division.
    task automatic expect_txn(input int p, input int pr, input int exp_stall);
        txn_t t;
        int   ch;
        int   n_hi;
        int   n_mid;
        int   n_lo;
        ch    = (p >= pr) ? p - pr : 0;
        n_hi  = ch / 10;
        n_mid = (ch % 10) / 5;
        n_lo  = ch % 5;
        for (int i = 0; i < n_hi;  i++) coin_q.push_back(SEL_HI);
        for (int i = 0; i < n_mid; i++) coin_q.push_back(SEL_MID);
        for (int i = 0; i < n_lo;  i++) coin_q.push_back(SEL_LO);
        t.change    = ch;
        t.short_e   = (p < pr) ? 1 : 0;
        t.ncoins    = n_hi + n_mid + n_lo;
        t.exp_stall = exp_stall;
        txn_q.push_back(t);
    endtask

    // coin_ready driver
    initial begin
        coin_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: coin_ready = 1'b1;
                1: coin_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_left > 0) begin
                        coin_ready = 1'b0;
                        if (coin_valid) stall_left--;
                    end else begin
                        coin_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        txn_t       t;
        logic [1:0] exp_sel;
        cyc++;
        if (!rst) begin
            if (start && !busy) begin
                start_cyc    = cyc;
                coins_seen   = 0;
                stalls       = 0;
                stalled_prev = 1'b0;
            end
            if (stalled_prev) begin
                check("valid_hold", {31'd0, coin_valid}, 1);
                if (coin_valid) check("sel_hold", {30'd0, coin_sel}, {30'd0, stalled_sel});
            end
            if (coin_valid) begin
                check("busy_in_disp", {31'd0, busy}, 1);
                if (coin_ready) begin
                    check("coin_expected", (coin_q.size() > 0) ? 1 : 0, 1);
                    if (coin_q.size() > 0) begin
                        exp_sel = coin_q.pop_front();
                        check("coin_sel", {30'd0, coin_sel}, {30'd0, exp_sel});
                    end
                    coins_seen++;
                    stalled_prev = 1'b0;
                end else begin
                    stalls++;
                    stalled_prev = 1'b1;
                    stalled_sel  = coin_sel;
                end
            end else begin
                stalled_prev = 1'b0;
            end
            if (short_err && !done) check("short_without_done", 1, {31'd0, done});
            if (done) begin
                check("done_expected", (txn_q.size() > 0) ? 1 : 0, 1);
                if (txn_q.size() > 0) begin
                    t = txn_q.pop_front();
                    check("change", {24'd0, change}, t.change);
                    check("short_err", {31'd0, short_err}, t.short_e);
                    check("coin_count", coins_seen, t.ncoins);
                    check("latency", cyc - start_cyc, 2 + t.ncoins + stalls);
                    if (t.exp_stall >= 0) check("stall_count", stalls, t.exp_stall);
`ifdef CHANGE_DISPENSER_COUNT_EN
                    check("coin_cnt", {24'd0, coin_cnt}, t.ncoins);
`endif
                end
                done_seen++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic issue_start(input int p, input int pr, input int exp_stall);
        @(posedge clk);
        #1;
        start = 1'b1;
        paid  = W'(p);
        price = W'(pr);
        expect_txn(p, pr, exp_stall);
        @(posedge clk);
        #1;
        start = 1'b0;
        paid  = W'($urandom);
        price = W'($urandom);
    endtask

    task automatic run_txn(input int p, input int pr, input int exp_stall);
        int target;
        int n = 0;
        wait_idle();
        target = done_seen + 1;
        issue_start(p, pr, exp_stall);
        while (done_seen < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", (done_seen >= target) ? 1 : 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_short_err"}, {31'd0, short_err}, 0);
        check({tag, "_change"}, {24'd0, change}, 0);
        check({tag, "_coin_valid"}, {31'd0, coin_valid}, 0);
        check({tag, "_coin_sel"}, {30'd0, coin_sel}, 0);
`ifdef CHANGE_DISPENSER_COUNT_EN
        check({tag, "_coin_cnt"}, {24'd0, coin_cnt}, 0);
`endif
    endtask

    initial begin
        int p;
        int pr;
        int d0;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        paid  = '0;
        price = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, ready always high
        ready_mode = 0;
        run_txn(20, 7, 0);    // 13 -> HI LO LO LO, done 6 cycles after start
        run_txn(25, 5, 0);    // 20 -> HI HI
        run_txn(7, 9, 0);     // short
        run_txn(12, 12, 0);   // exact
        run_txn(255, 0, 0);   // widest change
        run_txn(0, 255, 0);   // widest shortfall

        // First request stalled three cycles
        ready_mode = 2;
        stall_left = 3;
        run_txn(16, 0, 3);    // HI MID LO
        ready_mode = 0;

        // Reset after the first accepted coin
        wait_idle();
        issue_start(20, 7, -1);
        n = 0;
        while (coins_seen < 1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("first_coin_timeout", (coins_seen >= 1) ? 1 : 0, 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        coin_q.delete();
        txn_q.delete();
        d0 = done_seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("no_done_after_reset", done_seen, d0);
        run_txn(20, 7, 0);

        // Randomized transactions with random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            p  = $urandom_range(0, 80);
            pr = (i % 8 == 0) ? p : $urandom_range(0, 80);
            run_txn(p, pr, -1);
        end
        ready_mode = 0;

        repeat (3) @(posedge clk);
        check("coin_q_drained", coin_q.size(), 0);
        check("txn_q_drained", txn_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter W, 8: width of paid, price and change values.
REQ-002 Parameter COIN_HI, 10: largest coin denomination.
REQ-003 Parameter COIN_MID, 5: middle coin denomination.
REQ-004 Parameter COIN_LO, 1: smallest coin denomination; SHALL equal 1.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  request a change transaction; sampled only in IDLE.
REQ-008 paid  in  W  amount inserted by the customer, unsigned.
REQ-009 price  in  W  item price, unsigned.
REQ-010 busy  out  1  high in every state other than IDLE.
REQ-011 done  out  1  one-cycle pulse ending every transaction.
REQ-012 short_err  out  1  one-cycle pulse, coincident with done, when paid < price.
REQ-013 change  out  W  computed change (paid - price); held from CALC until the next start.
REQ-014 coin_valid  out  1  a coin request is presented.
REQ-015 coin_ready  in  1  the coin mechanism accepts the presented request.
REQ-016 coin_sel  out  2  denomination code: 00 LO, 01 MID, 10 HI; 11 never driven.

Function
REQ-017 States SHALL be IDLE, CALC, DISP and DONE.
REQ-018 IDLE with start=1 SHALL latch paid and price and go to CALC; start in any other state SHALL be ignored.
REQ-019 CALC SHALL form {0,paid} + {0,~price} + 1 in W+1 bits; borrow = NOT of bit W; diff = bits W-1:0.
REQ-020 CALC with borrow SHALL set change=0, pulse done and short_err in the next cycle (DONE state), and issue no coin.
REQ-021 CALC without borrow SHALL load change=diff and remaining=diff; go to DONE if diff=0, else to DISP.
REQ-022 DISP SHALL hold coin_valid=1 and select the largest denomination <= remaining (greedy).
REQ-023 coin_sel and coin_valid SHALL stay stable while coin_ready=0.
REQ-024 On coin_valid&coin_ready, remaining SHALL drop by the selected denomination; at 0, go to DONE with coin_valid=0 in the next cycle.
REQ-025 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-026 Latency from start to done SHALL be 2 cycles with no coins, else 2 + accepted-coin cycles + stall cycles.
REQ-027 Denomination comparisons SHALL be done at width W; the parameters SHALL fit in W bits.

Reset
REQ-028 rst SHALL force IDLE, busy=0, done=0, short_err=0, change=0, coin_valid=0, coin_sel=00 and remaining=0, immediately and independent of clk.
REQ-029 rst asserted mid-DISP SHALL abandon the transaction; no done pulse follows.

Configuration
REQ-030 With CHANGE_DISPENSER_COUNT_EN defined: extra output coin_cnt (W bits) SHALL count coins accepted in the current transaction; it clears on start and holds after done.
REQ-031 Without CHANGE_DISPENSER_COUNT_EN: no coin_cnt port and no counter logic.

Structure
REQ-032 A shared package vend_pkg SHALL hold the state enum (IDLE/CALC/DISP/DONE) and the coin_sel code constants.
REQ-033 A sub-module change_sub SHALL implement the W-bit two's-complement subtract (diff, borrow) used in CALC.

Verification
REQ-034 paid=20, price=7, ready always 1 -> change=13; coins HI, LO, LO, LO; done at cycle 6 after start; coin_cnt=4 when enabled.
REQ-035 paid=25, price=5 -> change=20; coins HI, HI; done once, short_err=0.
REQ-036 paid=7, price=9 -> short_err and done together 2 cycles after start; change=0; coin_valid never 1.
REQ-037 paid=price=12 -> done 2 cycles after start; change=0; no coin.
REQ-038 paid=16, price=0, coin_ready low 3 cycles on the first request -> coin_sel=10 held stable; sequence HI, MID, LO; done delayed 3 cycles.
REQ-039 rst pulsed after the first coin of paid=20, price=7 -> all outputs reset at once; no done; next start runs a clean transaction.
